// File: rtl/spi_cmd_tx.sv
// SPI mode-0 master that shifts one {cmd, data} control packet out MSB first.
// A start is taken only while idle; done pulses once csb has been high for CS_GAP cycles.
module spi_cmd_tx #(
  parameter int PACKET_WIDTH = 24,
  parameter int DATA_WIDTH   = 16,
  parameter int CLK_DIV      = 4,
  parameter int CS_GAP       = 2
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic [7:0]            cmd_word,
  input  logic [DATA_WIDTH-1:0] data_word,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  csb
);

  localparam int PH_W_DIV = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PH_W_GAP = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  // The phase counter also times the csb gap, so it must cover the larger of the two.
  localparam int PH_W     = (PH_W_DIV > PH_W_GAP) ? PH_W_DIV : PH_W_GAP;
  localparam int BIT_W    = $clog2(PACKET_WIDTH + 1);

  localparam logic [PH_W-1:0]  DIV_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  GAP_LAST = PH_W'(CS_GAP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PACKET_WIDTH - 1);

  typedef struct packed {
    logic [7:0]            cmd;
    logic [DATA_WIDTH-1:0] data;
  } pkt_t;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_GAP
  } state_t;

  state_t           state, state_nxt;
  logic [PH_W-1:0]  ph_cnt;
  logic [BIT_W-1:0] bit_cnt;
  pkt_t             sh_reg;
  logic             accept, ph_last;
  logic             sclk_nxt, csb_nxt, busy_nxt, done_nxt;

  assign accept  = (state == S_IDLE) && start;
  assign ph_last = (state == S_GAP) ? (ph_cnt == GAP_LAST) : (ph_cnt == DIV_LAST);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept)  state_nxt = S_SETUP;
      S_SETUP: if (ph_last) state_nxt = S_HIGH;
      S_HIGH:  if (ph_last) state_nxt = (bit_cnt == BIT_LAST) ? S_HOLD : S_LOW;
      S_LOW:   if (ph_last) state_nxt = S_HIGH;
      S_HOLD:  if (ph_last) state_nxt = S_GAP;
      S_GAP:   if (ph_last) state_nxt = S_IDLE;
      default:              state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each pin
  // changes on the same edge as the state it belongs to.
  always_comb begin
    sclk_nxt = (state_nxt == S_HIGH);
    csb_nxt  = (state_nxt == S_IDLE) || (state_nxt == S_GAP);
    busy_nxt = (state_nxt != S_IDLE);
    done_nxt = (state == S_GAP) && (state_nxt == S_IDLE);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk <= 1'b0;
      csb  <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      sclk <= sclk_nxt;
      csb  <= csb_nxt;
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)                                    ph_cnt <= '0;
    else if (state == S_IDLE || state_nxt != state) ph_cnt <= '0;
    else                                           ph_cnt <= ph_cnt + 1'b1;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)                          bit_cnt <= '0;
    else if (accept)                     bit_cnt <= '0;
    else if (state == S_HIGH && ph_last) bit_cnt <= bit_cnt + 1'b1;
  end

  // Shift on the falling sclk so mosi moves only while sclk is low.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)
      sh_reg <= '0;
    else if (accept)
      sh_reg <= '{cmd: cmd_word, data: data_word};
    else if (state == S_HIGH && state_nxt == S_LOW)
      sh_reg <= {sh_reg[$bits(pkt_t)-2:0], 1'b0};
  end

  assign mosi = sh_reg[$bits(pkt_t)-1];

endmodule

// File: tb/tb_spi_cmd_tx.sv
// Bench for spi_cmd_tx: default instance plus a CLK_DIV=2/CS_GAP=1 instance,
// with a frame scoreboard that reassembles mosi on sclk rising edges.
module tb_spi_cmd_tx;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  int   cyc     = 0;

  logic [7:0]  cmd0 = '0, cmd1 = '0;
  logic [15:0] data0 = '0, data1 = '0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic        busy_w[2], done_w[2], sclk_w[2], mosi_w[2], csb_w[2];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [23:0] bits;
    logic [31:0] t;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  spi_cmd_tx u0 (
    .sys_clk(sys_clk), .rst_n(rst_n), .cmd_word(cmd0), .data_word(data0), .start(start0),
    .busy(busy_w[0]), .done(done_w[0]), .sclk(sclk_w[0]), .mosi(mosi_w[0]), .csb(csb_w[0])
  );

  spi_cmd_tx #(.PACKET_WIDTH(24), .DATA_WIDTH(16), .CLK_DIV(2), .CS_GAP(1)) u1 (
    .sys_clk(sys_clk), .rst_n(rst_n), .cmd_word(cmd1), .data_word(data1), .start(start1),
    .busy(busy_w[1]), .done(done_w[1]), .sclk(sclk_w[1]), .mosi(mosi_w[1]), .csb(csb_w[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard. A sample taken after edge N shows the value the
  // timing description calls "at N+1", hence obs = cyc + 1.
  logic        prev_sclk[2] = '{1'b0, 1'b0};
  logic        prev_csb[2]  = '{1'b1, 1'b1};
  logic        prev_mosi[2] = '{1'b0, 1'b0};
  logic        prev_done[2] = '{1'b0, 1'b0};
  logic        in_fr[2]     = '{1'b0, 1'b0};
  logic [23:0] shv[2];
  int          nedge[2];
  int          done_due[2]  = '{0, 0};
  int          cd, gp, obs;
  exp_t        cur;
  logic        have;

  always @(negedge sys_clk) begin
    for (int i = 0; i < 2; i++) begin
      cd   = (i == 0) ? 4 : 2;
      gp   = (i == 0) ? 2 : 1;
      obs  = cyc + 1;
      have = 1'b0;
      if (i == 0 && q0.size() > 0) begin cur = q0[0]; have = 1'b1; end
      if (i == 1 && q1.size() > 0) begin cur = q1[0]; have = 1'b1; end
      if (!rst_n) begin
        if (in_fr[i] && have) begin
          if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        in_fr[i]    = 1'b0;
        done_due[i] = 0;
      end else begin
        if (sclk_w[i] !== prev_sclk[i] && csb_w[i] && prev_csb[i])
          chk($sformatf("sclk_edge_csb_high%0d", i), {31'd0, sclk_w[i]}, {31'd0, prev_sclk[i]});
        if (mosi_w[i] !== prev_mosi[i] && sclk_w[i])
          chk($sformatf("mosi_change_sclk_high%0d", i), {31'd0, mosi_w[i]}, {31'd0, prev_mosi[i]});
        if (prev_csb[i] && !csb_w[i]) begin
          if (have) chk($sformatf("csb_fall_time%0d", i), obs, cur.t + 1);
          else      chk($sformatf("unexpected_frame%0d", i), obs, 0);
          in_fr[i] = 1'b1;
          shv[i]   = '0;
          nedge[i] = 0;
        end
        if (!prev_sclk[i] && sclk_w[i]) begin
          shv[i]   = {shv[i][22:0], mosi_w[i]};
          nedge[i] = nedge[i] + 1;
        end
        if (!prev_csb[i] && csb_w[i] && in_fr[i]) begin
          in_fr[i] = 1'b0;
          if (have) begin
            chk($sformatf("frame_bits%0d", i), {8'd0, shv[i]}, {8'd0, cur.bits});
            chk($sformatf("sclk_rises%0d", i), nedge[i], 24);
            chk($sformatf("csb_rise_time%0d", i), obs, cur.t + 1 + cd * 49);
            done_due[i] = obs + gp;
            if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          end else begin
            chk($sformatf("frame_without_expect%0d", i), {8'd0, shv[i]}, 32'hFFFF_FFFF);
          end
        end
        if (done_w[i] && !prev_done[i]) begin
          if (done_due[i] != 0) chk($sformatf("done_time%0d", i), obs, done_due[i]);
          else                  chk($sformatf("unexpected_done%0d", i), obs, 0);
          done_due[i] = 0;
        end
        if (done_w[i] && prev_done[i])
          chk($sformatf("done_width%0d", i), {31'd0, done_w[i]}, 0);
      end
      prev_sclk[i] = sclk_w[i];
      prev_csb[i]  = csb_w[i];
      prev_mosi[i] = mosi_w[i];
      prev_done[i] = done_w[i];
    end
  end

  task automatic send(input int i, input logic [7:0] c, input logic [15:0] d,
                      input logic [23:0] eb);
    exp_t e;
    @(negedge sys_clk);
    e.bits = eb;
    e.t    = cyc + 1;
    if (i == 0) begin cmd0 = c; data0 = d; start0 = 1'b1; q0.push_back(e); end
    else        begin cmd1 = c; data1 = d; start1 = 1'b1; q1.push_back(e); end
    @(negedge sys_clk);
    if (i == 0) start0 = 1'b0; else start1 = 1'b0;
    chk($sformatf("busy_after_start%0d", i), {31'd0, busy_w[i]}, 1);
    chk($sformatf("csb_after_start%0d", i), {31'd0, csb_w[i]}, 0);
  endtask

  task automatic wait_done(input int i);
    int n;
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!done_w[i] && n < 2000);
    if (!done_w[i]) chk($sformatf("done_timeout%0d", i), n, 0);
  endtask

  initial begin
    exp_t e;
    repeat (3) @(negedge sys_clk);
    chk("rst_sclk", {31'd0, sclk_w[0]}, 0);
    chk("rst_csb",  {31'd0, csb_w[0]},  1);
    chk("rst_mosi", {31'd0, mosi_w[0]}, 0);
    chk("rst_busy", {31'd0, busy_w[0]}, 0);
    chk("rst_done", {31'd0, done_w[0]}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    send(0, 8'h81, 16'h1234, 24'h811234);
    wait_done(0);
    send(0, 8'h01, 16'hABCD, 24'h01ABCD);
    wait_done(0);

    // Start while busy is dropped; the frame must still carry the first packet.
    send(0, 8'h81, 16'h1234, 24'h811234);
    repeat (49) @(negedge sys_clk);
    cmd0 = 8'h55; data0 = 16'hAAAA; start0 = 1'b1;
    @(negedge sys_clk);
    start0 = 1'b0;
    chk("busy_after_ignored_start", {31'd0, busy_w[0]}, 1);
    wait_done(0);
    repeat (10) @(negedge sys_clk);

    // Back-to-back with start held high through the done cycle.
    @(negedge sys_clk);
    e.bits = 24'hFF0000; e.t = cyc + 1;
    cmd0 = 8'hFF; data0 = 16'h0000; start0 = 1'b1; q0.push_back(e);
    @(negedge sys_clk);
    cmd0 = 8'h00; data0 = 16'hFFFF;
    wait_done(0);
    e.bits = 24'h00FFFF; e.t = cyc + 1;
    q0.push_back(e);
    @(negedge sys_clk);
    start0 = 1'b0;
    wait_done(0);
    repeat (4) @(negedge sys_clk);

    // Reset mid-packet.
    send(0, 8'hC3, 16'h5A5A, 24'hC35A5A);
    repeat (99) @(negedge sys_clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_csb",  {31'd0, csb_w[0]},  1);
    chk("midrst_sclk", {31'd0, sclk_w[0]}, 0);
    chk("midrst_busy", {31'd0, busy_w[0]}, 0);
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    chk("post_rst_csb_idle",  {31'd0, csb_w[0]},  1);
    chk("post_rst_busy_idle", {31'd0, busy_w[0]}, 0);
    send(0, 8'h42, 16'h0F0F, 24'h420F0F);
    wait_done(0);

    // Fast-divider instance.
    send(1, 8'h81, 16'h1234, 24'h811234);
    wait_done(1);
    send(1, 8'h42, 16'h0F0F, 24'h420F0F);
    wait_done(1);

    repeat (10) @(negedge sys_clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("done_pending0", done_due[0], 0);
    chk("done_pending1", done_due[1], 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
